// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle sequencer.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             ir_we;
  logic             MemRead;
  logic             MemWrite;
  logic             iord;
  logic             RegWrite;
  logic             ALUSrc;
  logic [2:0]       op;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, ins, zero, mem_ready,
    output pc_we, pc_sel, ir_we, MemRead, MemWrite,
    output iord, RegWrite, ALUSrc, op, wb_sel,
    output illegal, busy, retired
  );

  modport slave (
    output run, ins, zero, mem_ready,
    input  pc_we, pc_sel, ir_we, MemRead, MemWrite,
    input  iord, RegWrite, ALUSrc, op, wb_sel,
    input  illegal, busy, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control sequencer.
// Optional retired counter: MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  state_e     state_q, state_d;
  logic [6:0] opc_q;
  logic [2:0] f3_q;
  logic       f7_q;

  logic [6:0] d_opc;
  logic [2:0] d_f3;
  logic [6:0] d_f7;
  logic       legal;
  logic       unused_ins;

  logic r_q, i_q, lw_q, sw_q, beq_q, jal_q;
  logic [2:0] alu_op;

  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic       mem_rd;
  logic       mem_wr;
  logic       iord;
  logic       reg_wr;
  logic       alu_src;
  logic [2:0] op;
  logic [1:0] wb_sel;
  logic       illegal;
  logic       busy;

  assign d_opc = bus.ins[6:0];
  assign d_f3  = bus.ins[14:12];
  assign d_f7  = bus.ins[31:25];
  assign unused_ins = ^{bus.ins[24:15], bus.ins[11:7]};

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      d_opc == OPC_R:
        legal = (d_f7 == 7'b0000000 &&
                 d_f3 inside {3'b000, 3'b111,
                              3'b110, 3'b010}) ||
                (d_f7 == 7'b0100000 &&
                 d_f3 == 3'b000);
      d_opc == OPC_I:
        legal = d_f3 inside {3'b000, 3'b111,
                             3'b110, 3'b010};
      d_opc == OPC_LW,
      d_opc == OPC_SW:
        legal = d_f3 == 3'b010;
      d_opc == OPC_BEQ:
        legal = d_f3 == 3'b000;
      d_opc == OPC_JAL:
        legal = 1'b1;
      default:
        legal = 1'b0;
    endcase
  end

  assign r_q   = opc_q == OPC_R;
  assign i_q   = opc_q == OPC_I;
  assign lw_q  = opc_q == OPC_LW;
  assign sw_q  = opc_q == OPC_SW;
  assign beq_q = opc_q == OPC_BEQ;
  assign jal_q = opc_q == OPC_JAL;

  // funct3 only selects the ALU op for R/I types
  always_comb begin
    alu_op = 3'b010;
    if (r_q || i_q) begin
      unique case (f3_q)
        3'b000:  alu_op = (r_q && f7_q) ? 3'b110
                                        : 3'b010;
        3'b111:  alu_op = 3'b000;
        3'b110:  alu_op = 3'b001;
        3'b010:  alu_op = 3'b111;
        default: alu_op = 3'b010;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opc_q <= d_opc;
        f3_q  <= d_f3;
        f7_q  <= d_f7[5];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    pc_sel  = 2'b00;
    ir_we   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    iord    = 1'b0;
    reg_wr  = 1'b0;
    alu_src = 1'b0;
    op      = 3'b010;
    wb_sel  = 2'b00;
    illegal = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      S_FETCH: begin
        busy = bus.run;
        if (bus.run) begin
          mem_rd = 1'b1;
          if (bus.mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        unique case (1'b1)
          r_q, i_q: begin
            alu_src = i_q;
            op      = alu_op;
            state_d = S_WB;
          end
          lw_q, sw_q: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          beq_q: begin
            op      = 3'b110;
            pc_we   = 1'b1;
            pc_sel  = bus.zero ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          jal_q: begin
            reg_wr  = 1'b1;
            wb_sel  = 2'b10;
            pc_we   = 1'b1;
            pc_sel  = 2'b10;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        iord    = 1'b1;
        alu_src = 1'b1;
        mem_rd  = lw_q;
        mem_wr  = sw_q;
        if (bus.mem_ready) begin
          if (lw_q) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_we   = 1'b1;
        wb_sel  = lw_q ? 2'b01 : 2'b00;
        alu_src = !r_q;
        op      = alu_op;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.pc_we    = pc_we;
  assign bus.pc_sel   = pc_sel;
  assign bus.ir_we    = ir_we;
  assign bus.MemRead  = mem_rd;
  assign bus.MemWrite = mem_wr;
  assign bus.iord     = iord;
  assign bus.RegWrite = reg_wr;
  assign bus.ALUSrc   = alu_src;
  assign bus.op       = op;
  assign bus.wb_sel   = wb_sel;
  assign bus.illegal  = illegal;
  assign bus.busy     = busy;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] ret_q, ret_d;

  assign ret_d = ret_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else if (pc_we) begin
      ret_q <= ret_d;
    end
  end

  assign bus.retired = ret_q;
`else
  assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl.
// Vectors are applied at negedge and checked 1ns later.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] SUB = 32'h402081B3;
  localparam logic [31:0] ORI = 32'h0050E193;
  localparam logic [31:0] SLT = 32'h0020A1B3;
  localparam logic [31:0] SW  = 32'h00512423;
  localparam logic [31:0] LW  = 32'h00812283;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] JAL = 32'h008000EF;
  localparam logic [31:0] BAD = 32'hFFFFFFFF;
  localparam logic [31:0] MUL = 32'h022081B3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run;
    logic [31:0] ins;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [CW-1:0] mret = '0;

  // {pc_we,pc_sel,ir_we,rd,wr,iord,rw,asrc,op,wb,ill,busy}
  function automatic logic [15:0] o(
    input logic       pcwe,
    input logic [1:0] pcs,
    input logic       irwe,
    input logic       mr,
    input logic       mw,
    input logic       io,
    input logic       rw,
    input logic       as,
    input logic [2:0] op,
    input logic [1:0] wb,
    input logic       ill,
    input logic       bsy
  );
    return {pcwe, pcs, irwe, mr, mw, io, rw,
            as, op, wb, ill, bsy};
  endfunction

  function automatic logic [15:0] act();
    return {bus.pc_we, bus.pc_sel, bus.ir_we,
            bus.MemRead, bus.MemWrite, bus.iord,
            bus.RegWrite, bus.ALUSrc, bus.op,
            bus.wb_sel, bus.illegal, bus.busy};
  endfunction

  function automatic logic [CW-1:0] exp_ret();
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    return mret;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               n, a, e);
    end
  endtask

  task automatic push(input string n,
                      input logic r,
                      input logic [31:0] i,
                      input logic z,
                      input logic rd,
                      input logic [15:0] e);
    vec_t v;
    v.name = n;
    v.run  = r;
    v.ins  = i;
    v.zero = z;
    v.rdy  = rd;
    v.exp  = e;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r,
                       input logic [31:0] i,
                       input logic z,
                       input logic rd);
    bus.run       = r;
    bus.ins       = i;
    bus.zero      = z;
    bus.mem_ready = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    mret  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] IDLE, FET, FWT, DEC, ILL;

  initial begin
    IDLE = o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0, 0);
    FET  = o(0, 2'b00, 1, 1, 0, 0, 0, 0, 3'b010, 2'b00, 0, 1);
    FWT  = o(0, 2'b00, 0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 0, 1);
    DEC  = o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0, 1);
    ILL  = o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 1, 1);

    push("idle",    0, 32'h0, 0, 1, IDLE);
    push("add_f",   1, ADD, 0, 1, FET);
    push("add_d",   1, ADD, 0, 1, DEC);
    push("add_e",   1, ADD, 0, 1,
         o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0, 1));
    push("add_wb",  1, ADD, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00, 0, 1));
    push("sub_f",   1, SUB, 0, 1, FET);
    push("sub_d",   1, SUB, 0, 1, DEC);
    push("sub_e",   1, SUB, 0, 1,
         o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, 0, 1));
    push("sub_wb",  1, SUB, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 1, 0, 3'b110, 2'b00, 0, 1));
    push("ori_f",   1, ORI, 0, 1, FET);
    push("ori_d",   1, ORI, 0, 1, DEC);
    push("ori_e",   1, ORI, 0, 1,
         o(0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 2'b00, 0, 1));
    push("ori_wb",  1, ORI, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 1, 1, 3'b001, 2'b00, 0, 1));
    push("slt_f",   1, SLT, 0, 1, FET);
    push("slt_d",   1, SLT, 0, 1, DEC);
    push("slt_e",   1, SLT, 0, 1,
         o(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0, 1));
    push("slt_wb",  1, SLT, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 1, 0, 3'b111, 2'b00, 0, 1));
    push("sw_f",    1, SW, 0, 1, FET);
    push("sw_d",    1, SW, 0, 1, DEC);
    push("sw_e",    1, SW, 0, 1,
         o(0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 0, 1));
    push("sw_m",    1, SW, 0, 1,
         o(1, 2'b00, 0, 0, 1, 1, 0, 1, 3'b010, 2'b00, 0, 1));
    push("lw_fw",   1, LW, 0, 0, FWT);
    push("lw_f",    1, LW, 0, 1, FET);
    push("lw_d",    0, LW, 0, 0, DEC);
    push("lw_e",    0, LW, 0, 0,
         o(0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 0, 1));
    push("lw_m0",   0, LW, 0, 0,
         o(0, 2'b00, 0, 1, 0, 1, 0, 1, 3'b010, 2'b00, 0, 1));
    push("lw_m1",   0, LW, 0, 0,
         o(0, 2'b00, 0, 1, 0, 1, 0, 1, 3'b010, 2'b00, 0, 1));
    push("lw_m2",   0, LW, 0, 1,
         o(0, 2'b00, 0, 1, 0, 1, 0, 1, 3'b010, 2'b00, 0, 1));
    push("lw_wb",   0, LW, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 1, 1, 3'b010, 2'b01, 0, 1));
    push("lw_idle", 0, LW, 0, 1, IDLE);
    push("beq1_f",  1, BEQ, 0, 1, FET);
    push("beq1_d",  1, BEQ, 0, 1, DEC);
    push("beq1_e",  1, BEQ, 1, 1,
         o(1, 2'b01, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, 0, 1));
    push("beq0_f",  1, BEQ, 1, 1, FET);
    push("beq0_d",  1, BEQ, 1, 1, DEC);
    push("beq0_e",  1, BEQ, 0, 1,
         o(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, 0, 1));
    push("jal_f",   1, JAL, 0, 1, FET);
    push("jal_d",   1, JAL, 0, 1, DEC);
    push("jal_e",   1, JAL, 0, 1,
         o(1, 2'b10, 0, 0, 0, 0, 1, 0, 3'b010, 2'b10, 0, 1));
    push("end",     0, JAL, 0, 1, IDLE);

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("reset_out", 32'(act()), 32'(IDLE));
    chk("reset_ret", 32'(bus.retired), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].run, vq[k].ins, vq[k].zero, vq[k].rdy);
      #1;
      chk(vq[k].name, 32'(act()), 32'(vq[k].exp));
      chk({vq[k].name, "_ret"}, 32'(bus.retired),
          32'(exp_ret()));
      if (vq[k].exp[15]) mret = mret + 1'b1;
    end

    // illegal opcode: sticky trap, no strobes
    do_reset();
    @(negedge clk);
    drive(1'b1, BAD, 1'b0, 1'b1);
    #1 chk("bad_f", 32'(act()), 32'(FET));
    @(negedge clk);
    #1 chk("bad_d", 32'(act()), 32'(DEC));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(c[0], BAD, c[1], c[2]);
      #1 chk($sformatf("trap_%0d", c),
             32'(act()), 32'(ILL));
    end
    chk("trap_ret", 32'(bus.retired), 32'(0));
    drive(1'b0, BAD, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk("trap_rst", 32'(act()), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // unsupported funct7 on R-type
    @(negedge clk);
    drive(1'b1, MUL, 1'b0, 1'b1);
    #1 chk("mul_f", 32'(act()), 32'(FET));
    @(negedge clk);
    #1 chk("mul_d", 32'(act()), 32'(DEC));
    @(negedge clk);
    #1 chk("mul_trap", 32'(act()), 32'(ILL));

    // reset during WB of add aborts the write
    do_reset();
    @(negedge clk);
    drive(1'b1, ADD, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1 chk("abort_wb", 32'(bus.RegWrite), 32'(1));
    #2 rst_n = 1'b0;
    drive(1'b0, ADD, 1'b0, 1'b1);
    #1 chk("abort_rst", 32'(act()), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_idle_%0d", c),
             32'(act()), 32'(IDLE));
    end
    chk("abort_ret", 32'(bus.retired), 32'(0));

    // 17 retirements wrap a 4-bit counter to 1
    do_reset();
    for (int c = 0; c < 17 * 3; c++) begin
      @(negedge clk);
      drive(1'b1, JAL, 1'b0, 1'b1);
      #1;
      if (bus.pc_we) mret = mret + 1'b1;
    end
    @(negedge clk);
    drive(1'b0, JAL, 1'b0, 1'b1);
    #1 chk("wrap_ret", 32'(bus.retired),
           32'(exp_ret()));
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chk("wrap_one", 32'(bus.retired), 32'(1));
`else
    chk("wrap_zero", 32'(bus.retired), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
